// File: rtl/codec_init_seq_if.sv
// I2C request bundle between the codec init sequencer and the byte master.
// master: the sequencer side; slave: the i2c_fsm side.
interface codec_init_seq_if;
    logic       i2c_start;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_byte0;
    logic [7:0] i2c_byte1;
    logic       i2c_busy;
    logic       i2c_done;
    logic       i2c_nack;

    modport master (
        output i2c_start,
        output i2c_dev_addr,
        output i2c_byte0,
        output i2c_byte1,
        input  i2c_busy,
        input  i2c_done,
        input  i2c_nack
    );

    modport slave (
        input  i2c_start,
        input  i2c_dev_addr,
        input  i2c_byte0,
        input  i2c_byte1,
        output i2c_busy,
        output i2c_done,
        output i2c_nack
    );
endinterface

// File: rtl/codec_init_seq.sv
// Codec register-table init sequencer feeding the I2C byte master.
// Power-up wait, table walk, bounded retry on NACK/timeout, debug state code.
module codec_init_seq #(
    parameter int         NUM_REGS     = 10,
    parameter logic [6:0] DEV_ADDR     = 7'h1A,
    parameter int         STARTUP_WAIT = 1000,
    parameter int         MAX_RETRY    = 3,
    parameter int         RETRY_GAP    = 100,
    parameter int         TIMEOUT      = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    output logic [7:0]              rom_addr,
    input  logic [15:0]             rom_data,
    codec_init_seq_if.master        i2c,
    output logic                    init_done,
    output logic                    init_error,
    output logic [7:0]              reg_index,
    output logic [3:0]              state_info
);

    typedef enum logic [3:0] {
        S_WAIT      = 4'd1,
        S_FETCH     = 4'd2,
        S_LATCH     = 4'd3,
        S_ISSUE     = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_CHECK     = 4'd6,
        S_BACKOFF   = 4'd7,
        S_DONE      = 4'd8,
        S_ERROR     = 4'd9
    } state_t;

    localparam int CNT_A   = (TIMEOUT > STARTUP_WAIT) ? TIMEOUT : STARTUP_WAIT;
    localparam int CNT_MAX = (CNT_A > RETRY_GAP) ? CNT_A : RETRY_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 2);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   retry;
    logic            nack_q;
    logic            cnt_en;
    logic            wait_end;
    logic            tmo;
    logic            gap_end;
    logic            last_reg;
    logic            can_retry;

    assign i2c.i2c_dev_addr = DEV_ADDR;

    assign cnt_en    = (state == S_WAIT) || (state == S_WAIT_DONE) ||
                       (state == S_BACKOFF);
    assign wait_end  = (cnt == CW'(STARTUP_WAIT - 1));
    assign tmo       = (cnt == CW'(TIMEOUT - 1));
    assign gap_end   = (cnt == CW'(RETRY_GAP - 1));
    assign last_reg  = (reg_index == 8'(NUM_REGS - 1));
    assign can_retry = (retry < RW'(MAX_RETRY));

    // State register; reset lands in the power-up wait from anywhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; done beats a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT: begin
                if (wait_end) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!i2c.i2c_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i2c.i2c_done || tmo) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!nack_q) begin
                    state_nxt = last_reg ? S_DONE : S_FETCH;
                end else begin
                    state_nxt = can_retry ? S_BACKOFF : S_ERROR;
                end
            end
            S_BACKOFF: begin
                if (gap_end) state_nxt = S_ISSUE;
            end
            S_DONE, S_ERROR: begin
                if (restart) state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        state_info = state;
        init_done  = (state == S_DONE);
        init_error = (state == S_ERROR);
    end

    // Datapath: shared cycle counter, table index, latched bytes, retries.
    // rom_addr tracks reg_index so a registered ROM has data by LATCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt           <= '0;
            retry         <= '0;
            nack_q        <= 1'b0;
            reg_index     <= '0;
            rom_addr      <= '0;
            i2c.i2c_start <= 1'b0;
            i2c.i2c_byte0 <= '0;
            i2c.i2c_byte1 <= '0;
        end else begin
            i2c.i2c_start <= 1'b0;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_en) begin
                cnt <= cnt + CW'(1);
            end
            unique case (state)
                S_FETCH: rom_addr <= reg_index;
                S_LATCH: begin
                    i2c.i2c_byte0 <= rom_data[15:8];
                    i2c.i2c_byte1 <= rom_data[7:0];
                end
                S_ISSUE: begin
                    if (!i2c.i2c_busy) i2c.i2c_start <= 1'b1;
                end
                S_WAIT_DONE: begin
                    if (i2c.i2c_done) begin
                        nack_q <= i2c.i2c_nack;
                    end else if (tmo) begin
                        nack_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!nack_q) begin
                        retry <= '0;
                        if (!last_reg) begin
                            reg_index <= reg_index + 8'd1;
                            rom_addr  <= reg_index + 8'd1;
                        end
                    end else if (can_retry) begin
                        retry <= retry + RW'(1);
                    end
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        reg_index <= '0;
                        rom_addr  <= '0;
                        retry     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
